bcd_updown_counter: RTL and testbench

BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

---
 rtl/bcd_updown_counter_if.sv | 26 ++
 rtl/bcd_updown_counter.sv | 80 ++++++++
 tb/tb_bcd_updown_counter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_updown_counter_if.sv
// Control and status bundle for the cascaded BCD up/down counter.
// Latency: n/a (wires only).
// Backpressure: none; en qualifies each count step, there is no ready.
interface bcd_updown_counter_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   count;
  logic                  tc;
  logic                  load_err;

  // Controller side drives the request, observes the count.
  modport master (
    output en, up, load, load_val,
    input  count, tc, load_err
  );

  // Counter side.
  modport slave (
    input  en, up, load, load_val,
    output count, tc, load_err
  );
endinterface

// File: rtl/bcd_updown_counter.sv
// Cascaded BCD up/down counter with parallel load, wrap or saturate at the limits.
// Latency: one clk edge from en/load to count; tc and load_err are one-cycle registered pulses.
// Backpressure: none; the counter accepts a step or load on every edge.
module bcd_updown_counter #(
  parameter int DIGITS   = 4,     // legal range 1..8
  parameter bit SATURATE = 1'b0   // 0: wrap at the limits, 1: hold at the limits
) (
  input  logic                  clk,
  input  logic                  reset,
  bcd_updown_counter_if.slave   bus
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] count_q;
  logic         tc_q;
  logic         load_err_q;

  logic [W-1:0] step_val;   // count after one up/down step, wrapped
  logic         chain;      // carry/borrow propagating through the digits
  logic         at_limit;   // every digit is 9 (up) or 0 (down)
  logic         load_ok;    // every load nibble is a valid BCD digit

  // Reject a load if any nibble is outside 0..9.
  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.load_val[4*i +: 4] > 4'd9) begin
        load_ok = 1'b0;
      end
    end
  end

  // Single-edge carry/borrow chain: a digit steps only when all lower digits sit at the limit.
  always_comb begin
    step_val = count_q;
    chain    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (chain) begin
        if (bus.up) begin
          step_val[4*i +: 4] = (count_q[4*i +: 4] == 4'd9) ? 4'd0 : count_q[4*i +: 4] + 4'd1;
        end else begin
          step_val[4*i +: 4] = (count_q[4*i +: 4] == 4'd0) ? 4'd9 : count_q[4*i +: 4] - 4'd1;
        end
      end
      chain = chain & (bus.up ? (count_q[4*i +: 4] == 4'd9) : (count_q[4*i +: 4] == 4'd0));
    end
    at_limit = chain;
  end

  // State update: reset, then load, then count, else hold; pulses default low each edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
      if (bus.load) begin
        // A bad load leaves the count alone and the step request is dropped.
        if (load_ok) begin
          count_q <= bus.load_val;
        end else begin
          load_err_q <= 1'b1;
        end
      end else if (bus.en) begin
        tc_q <= at_limit;
        if (!(at_limit && SATURATE)) begin
          count_q <= step_val;
        end
      end
    end
  end

  assign bus.count    = count_q;
  assign bus.tc       = tc_q;
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Self-checking bench: a wrap-mode and a saturate-mode counter driven in lockstep.
// Latency: outputs checked 1 time unit after each rising clk edge.
// Backpressure: none exercised; the counter has no ready.
module tb_bcd_updown_counter;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  bcd_updown_counter_if #(.DIGITS(4)) ifw ();
  bcd_updown_counter_if #(.DIGITS(4)) ifs ();

  bcd_updown_counter #(.DIGITS(4), .SATURATE(1'b0)) dut_w (
    .clk   (clk),
    .reset (reset),
    .bus   (ifw)
  );

  bcd_updown_counter #(.DIGITS(4), .SATURATE(1'b1)) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (ifs)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: counts held as plain integers 0..9999.
  int mw, ms;
  bit mtw, mts, mew, mes;

  typedef struct {
    logic        en;
    logic        up;
    logic        load;
    logic [15:0] lv;
    logic [15:0] cw;
    logic        tcw;
    logic [15:0] cs;
    logic        tcs;
    logic        err;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic up, input logic load, input logic [15:0] lv);
    ifw.en = en; ifw.up = up; ifw.load = load; ifw.load_val = lv;
    ifs.en = en; ifs.up = up; ifs.load = load; ifs.load_val = lv;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int n);
    logic [15:0] r = '0;
    int k = n;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(k % 10);
      k = k / 10;
    end
    return r;
  endfunction

  function automatic bit bcd_legal(input logic [15:0] v);
    for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  // Behavioural counter: integer arithmetic modulo 10000 with explicit limit handling.
  function automatic void model_step(input bit sat, input logic en, input logic up,
                                     input logic load, input logic [15:0] lv,
                                     input int cur, output int nxt, output bit tc, output bit err);
    nxt = cur; tc = 1'b0; err = 1'b0;
    if (load) begin
      if (bcd_legal(lv)) nxt = bcd2int(lv);
      else err = 1'b1;
    end else if (en) begin
      if (up) begin
        if (cur == 9999) begin tc = 1'b1; nxt = sat ? 9999 : 0; end
        else nxt = cur + 1;
      end else begin
        if (cur == 0) begin tc = 1'b1; nxt = sat ? 0 : 9999; end
        else nxt = cur - 1;
      end
    end
  endfunction

  task automatic check_model(input string tag);
    chk({tag, " count_w"}, 32'(ifw.count),    32'(int2bcd(mw)));
    chk({tag, " tc_w"},    32'(ifw.tc),       32'(mtw));
    chk({tag, " err_w"},   32'(ifw.load_err), 32'(mew));
    chk({tag, " count_s"}, 32'(ifs.count),    32'(int2bcd(ms)));
    chk({tag, " tc_s"},    32'(ifs.tc),       32'(mts));
    chk({tag, " err_s"},   32'(ifs.load_err), 32'(mes));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [15:0] lv;
    logic        ren, rup, rload;
    int          nw, ns;

    //            en    up    load  lv        cw        tcw   cs        tcs   err
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 16'h0999, 16'h0999, 1'b0, 16'h0999, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h1000, 1'b0, 16'h1000, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 16'h9999, 16'h9999, 1'b0, 16'h9999, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h9999, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h9999, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h9999, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h9998, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 16'h0057, 16'h0057, 1'b0, 16'h0057, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 16'h12A4, 16'h0057, 1'b0, 16'h0057, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0057, 1'b0, 16'h0057, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 16'h0090, 16'h0090, 1'b0, 16'h0090, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0089, 1'b0, 16'h0089, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h0090, 1'b0, 16'h0090, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 16'h000F, 16'h0090, 1'b0, 16'h0090, 1'b0, 1'b1};

    // Reset state, observed before reset is released.
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    #7;
    chk("reset count_w", 32'(ifw.count), 32'h0);
    chk("reset count_s", 32'(ifs.count), 32'h0);
    chk("reset tc",      32'({ifw.tc, ifs.tc}), 32'h0);
    chk("reset err",     32'({ifw.load_err, ifs.load_err}), 32'h0);
    reset = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].en, tbl[i].up, tbl[i].load, tbl[i].lv);
      step();
      chk($sformatf("vec%0d count_w", i), 32'(ifw.count),    32'(tbl[i].cw));
      chk($sformatf("vec%0d tc_w", i),    32'(ifw.tc),       32'(tbl[i].tcw));
      chk($sformatf("vec%0d count_s", i), 32'(ifs.count),    32'(tbl[i].cs));
      chk($sformatf("vec%0d tc_s", i),    32'(ifs.tc),       32'(tbl[i].tcs));
      chk($sformatf("vec%0d err_w", i),   32'(ifw.load_err), 32'(tbl[i].err));
      chk($sformatf("vec%0d err_s", i),   32'(ifs.load_err), 32'(tbl[i].err));
    end

    // Reset mid-cycle, then ten up-counts: decade carry at the tenth edge, no tc.
    reset = 1'b1;
    #2;
    chk("midreset count_w", 32'(ifw.count), 32'h0);
    chk("midreset count_s", 32'(ifs.count), 32'h0);
    drive(1'b1, 1'b1, 1'b0, 16'h0000);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("up10 tc_w e%0d", i), 32'(ifw.tc), 32'h0);
      chk($sformatf("up10 tc_s e%0d", i), 32'(ifs.tc), 32'h0);
    end
    chk("up10 count_w", 32'(ifw.count), 32'h0010);
    chk("up10 count_s", 32'(ifs.count), 32'h0010);

    // Load 0321, then wrap to raise tc, then reset between edges clears count and the pulse.
    drive(1'b0, 1'b0, 1'b1, 16'h0321);
    step();
    chk("load0321 count_w", 32'(ifw.count), 32'h0321);
    drive(1'b0, 1'b0, 1'b1, 16'h9999);
    step();
    drive(1'b1, 1'b1, 1'b0, 16'h0000);
    step();
    chk("wrap tc_w", 32'(ifw.tc), 32'h1);
    chk("sat tc_s",  32'(ifs.tc), 32'h1);
    reset = 1'b1;
    #2;
    chk("async count_w", 32'(ifw.count), 32'h0);
    chk("async count_s", 32'(ifs.count), 32'h0);
    chk("async tc cleared", 32'({ifw.tc, ifs.tc}), 32'h0);
    drive(1'b1, 1'b1, 1'b1, 16'h0321);
    #1;
    reset = 1'b0;
    step();
    chk("post-reset load count_w", 32'(ifw.count), 32'h0321);
    chk("post-reset load count_s", 32'(ifs.count), 32'h0321);
    chk("post-reset load tc", 32'({ifw.tc, ifs.tc}), 32'h0);

    // Random traffic against the integer reference model.
    mw = 321; ms = 321;
    for (int i = 0; i < 600; i++) begin
      ren   = ($urandom_range(0, 3) != 0);
      rup   = $urandom_range(0, 1);
      rload = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 7))
        0:       lv = 16'($urandom);
        1:       lv = 16'h9999;
        2:       lv = 16'h0000;
        3:       lv = 16'h9995;
        default: lv = int2bcd($urandom_range(0, 9999));
      endcase
      drive(ren, rup, rload, lv);
      step();
      model_step(1'b0, ren, rup, rload, lv, mw, nw, mtw, mew);
      model_step(1'b1, ren, rup, rload, lv, ms, ns, mts, mes);
      mw = nw; ms = ns;
      check_model($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
